btn_cmd_scheduler: RTL and testbench
====================================

BTN_CMD_SCHEDULER -- requirements
Module: btn_cmd_scheduler

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, system clock frequency.
REQ-002 SHALL have parameter SAMPLE_HZ, default 1000, debounce sample rate; CLK_HZ/SAMPLE_HZ >= 2.
REQ-003 SHALL have parameter DEPTH, default 14, shift-register length per button.
REQ-004 SHALL have parameter LONG_TICKS, default 1000, sample ticks of hold before the first long command.
REQ-005 SHALL have parameter REPEAT_TICKS, default 200, sample ticks between auto-repeat commands.
REQ-006 SHALL have port clk, input, 1, single system clock; rst, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port btn, input, 5, raw buttons, index 0..4 = C, U, D, L, R.
REQ-008 SHALL have port cmd_valid, output, 1, command available.
REQ-009 SHALL have port cmd_ready, input, 1, consumer accepts command.
REQ-010 SHALL have port cmd_id, output, 3, button index of command, 0..4.
REQ-011 SHALL have port cmd_long, output, 1, 1 = long/repeat command, 0 = short press.
REQ-012 SHALL have port btn_level, output, 5, debounced level per button.

Function
REQ-013 SHALL generate a one-clock sample tick every CLK_HZ/SAMPLE_HZ clocks using a free-running divider that wraps to 0.
REQ-014 SHALL shift each btn bit into its DEPTH-bit register only on tick; btn_level[i] SHALL be set when all bits are 1, cleared when all bits are 0, and otherwise held.
REQ-015 SHALL set pending[i] one clock after btn_level[i] rises; pending[i] SHALL stay set until its command is accepted.
REQ-016 SHALL load the output register when it is empty or being accepted, selecting the lowest-index pending bit (C highest priority); it SHALL clear that pending bit in the same clock.
REQ-017 SHALL hold cmd_valid, cmd_id and cmd_long stable until the clock where cmd_valid && cmd_ready.
REQ-018 SHALL assert cmd_valid 2 clocks after btn_level[i] rises when the output register is empty, cmd_ready=1, and no other bit is pending.
REQ-019 SHALL run a hold FSM: IDLE -> HELD when a short command for button k loads (k latched, hold counter = 0); HELD -> REPEAT when k has stayed level-high for LONG_TICKS ticks; in REPEAT, every REPEAT_TICKS ticks; any state -> IDLE when btn_level[k] falls.
REQ-020 SHALL raise a long request on each HELD->REPEAT transition and each REPEAT period; it SHALL be served with id k, cmd_long=1, and lower priority than any pending short press.
REQ-021 SHALL keep at most one long request outstanding; a repeat period that expires while one is outstanding SHALL be dropped, not queued.
REQ-022 SHALL cancel an outstanding long request when btn_level[k] falls, unless that request is already in the output register.
REQ-023 SHALL record a press of another button during HELD/REPEAT as pending; when served, that press SHALL retarget the FSM to HELD for the new button.
REQ-024 SHALL saturate the hold counter and SHALL make it count ticks, not clocks.

Reset
REQ-025 SHALL, while rst=1, clear the divider, shift registers, btn_level, pending, long request, hold counter, FSM (IDLE), cmd_valid, cmd_id and cmd_long to 0.
REQ-026 SHALL discard a reset asserted mid-hold or mid-handshake: no command is issued for buttons already high at reset release until DEPTH ticks of 1 have been sampled.

Structure
REQ-027 SHALL place button index constants (BTN_C..BTN_R), FSM state encodings and the cmd_id width in shared package btn_pkg.
REQ-028 SHALL implement each button's tick-gated shift debouncer as one sub-module, btn_debounce_tick, instantiated 5 times; the divider, arbiter and FSM SHALL be top-level.

Verification (CLK_HZ=1000, SAMPLE_HZ=100, DEPTH=4, LONG_TICKS=20, REPEAT_TICKS=5)
REQ-029 SHALL cover: btn[1] high for 60 clocks, cmd_ready=1 -> exactly one cmd with id=1, long=0; btn_level[1] high after the 4th tick.
REQ-030 SHALL cover: btn[3] toggling every 7 clocks for 200 clocks -> btn_level[3] stays 0 and no cmd is issued.
REQ-031 SHALL cover: btn[0] and btn[4] rising in the same clock -> cmd id=0 followed by id=4, one clock apart, with cmd_ready=1.
REQ-032 SHALL cover: cmd_ready=0 for 50 clocks during a press of btn[2] -> cmd_valid held and id=2 stable; accepted on the first clock cmd_ready=1.
REQ-033 SHALL cover: btn[0] held for 400 clocks -> 1 short cmd, long cmd 200 clocks after btn_level rises, then long cmds every 50 clocks; none after release.
REQ-034 SHALL cover: rst pulsed while in REPEAT with cmd_valid=1 -> all outputs 0 next clock; no cmd until 4 ticks after release.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared constants and types for the button command scheduler.
package btn_pkg;

  localparam int unsigned NUM_BTN = 5;
  localparam int unsigned ID_W    = 3;

  localparam logic [ID_W-1:0] BTN_C = 3'd0;
  localparam logic [ID_W-1:0] BTN_U = 3'd1;
  localparam logic [ID_W-1:0] BTN_D = 3'd2;
  localparam logic [ID_W-1:0] BTN_L = 3'd3;
  localparam logic [ID_W-1:0] BTN_R = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } hold_state_e;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            is_long;
  } cmd_t;

endpackage

// File: rtl/btn_debounce_tick.sv
// Tick-gated shift-register debouncer for one button: the level flips only
// after DEPTH consecutive identical samples.
module btn_debounce_tick #(
  parameter int unsigned DEPTH = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic btn_i,
  output logic level_o
);

  logic [DEPTH-1:0] sh_q, sh_d, shifted;
  logic             level_q, level_d;

  assign shifted = {sh_q[DEPTH-2:0], btn_i};

  always_comb begin
    sh_d    = sh_q;
    level_d = level_q;
    if (tick_i) begin
      sh_d = shifted;
      if (&shifted) begin
        level_d = 1'b1;
      end else if (~|shifted) begin
        level_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q    <= '0;
      level_q <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      level_q <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/btn_cmd_scheduler.sv
// Debounces five buttons and issues short-press and long/auto-repeat commands
// through a single valid/ready output register.
module btn_cmd_scheduler
  import btn_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned SAMPLE_HZ    = 1000,
  parameter int unsigned DEPTH        = 14,
  parameter int unsigned LONG_TICKS   = 1000,
  parameter int unsigned REPEAT_TICKS = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [ID_W-1:0]    cmd_id,
  output logic               cmd_long,
  output logic [NUM_BTN-1:0] btn_level
);

  localparam int unsigned DIV      = CLK_HZ / SAMPLE_HZ;
  localparam int unsigned DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int unsigned CNT_W    = $clog2(HOLD_MAX + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);

  logic [DIV_W-1:0]   div_q, div_d;
  logic               sample_tick;
  logic [NUM_BTN-1:0] level, level_prev_q, rise;
  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic               long_req_q, long_req_d;
  hold_state_e        state_q, state_d;
  logic [ID_W-1:0]    k_q, k_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  cmd_t               out_q, out_d;
  logic               valid_q, valid_d;
  logic [ID_W-1:0]    sel_id;
  logic               sel_any, short_load, long_set, long_busy, k_level;

  // Free-running sample divider; tick on the last count before wrap.
  assign sample_tick = (div_q == DIV_LAST);
  assign div_d       = sample_tick ? '0 : div_q + DIV_W'(1);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce_tick #(.DEPTH(DEPTH)) u_db (
      .clk     (clk),
      .rst     (rst),
      .tick_i  (sample_tick),
      .btn_i   (btn[i]),
      .level_o (level[i])
    );
  end

  assign rise      = level & ~level_prev_q;
  assign k_level   = level[k_q];
  assign cnt_inc   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
  assign long_busy = long_req_q | (valid_q & out_q.is_long);

  // Lowest index wins: C has highest priority.
  always_comb begin
    sel_id  = BTN_C;
    sel_any = 1'b0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_id  = ID_W'(i);
        sel_any = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    long_req_d = long_req_q;
    pending_d  = pending_q | rise;
    out_d      = out_q;
    valid_d    = valid_q;
    short_load = 1'b0;
    long_set   = 1'b0;

    // Output register refills when empty or being accepted.
    if (!valid_q || cmd_ready) begin
      valid_d = 1'b0;
      if (sel_any) begin
        valid_d           = 1'b1;
        out_d             = '{id: sel_id, is_long: 1'b0};
        pending_d[sel_id] = 1'b0;
        short_load        = 1'b1;
      end else if (long_req_q && k_level) begin
        valid_d    = 1'b1;
        out_d      = '{id: k_q, is_long: 1'b1};
        long_req_d = 1'b0;
      end
    end

    // A served short press (re)targets the hold FSM; release of k cancels it.
    if (short_load) begin
      state_d    = ST_HELD;
      k_d        = sel_id;
      cnt_d      = '0;
      long_req_d = 1'b0;
    end else if (state_q != ST_IDLE && !k_level) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      long_req_d = 1'b0;
    end else if (sample_tick) begin
      case (state_q)
        ST_HELD: begin
          if (cnt_q >= LONG_LAST) begin
            state_d  = ST_REPEAT;
            cnt_d    = '0;
            long_set = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_REPEAT: begin
          if (cnt_q >= REP_LAST) begin
            cnt_d    = '0;
            long_set = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end

    // Expiring period while a long command is still in flight is dropped.
    if (long_set && !long_busy) begin
      long_req_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q        <= '0;
      level_prev_q <= '0;
      pending_q    <= '0;
      long_req_q   <= 1'b0;
      state_q      <= ST_IDLE;
      k_q          <= BTN_C;
      cnt_q        <= '0;
      out_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      div_q        <= div_d;
      level_prev_q <= level;
      pending_q    <= pending_d;
      long_req_q   <= long_req_d;
      state_q      <= state_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      out_q        <= out_d;
      valid_q      <= valid_d;
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_id    = out_q.id;
  assign cmd_long  = out_q.is_long;
  assign btn_level = level;

endmodule

// File: tb/tb_btn_cmd_scheduler.sv
// Self-checking bench for btn_cmd_scheduler with a fast clock/sample setup
// (10 clocks per sample tick, 4-deep debounce, 20/5 tick long/repeat).
module tb_btn_cmd_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn = '0;
  logic       cmd_ready = 1'b1;
  logic       cmd_valid;
  logic [2:0] cmd_id;
  logic       cmd_long;
  logic [4:0] btn_level;

  int tests = 0;
  int fails = 0;

  btn_cmd_scheduler #(
    .CLK_HZ(1000), .SAMPLE_HZ(100), .DEPTH(4), .LONG_TICKS(20), .REPEAT_TICKS(5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_id    (cmd_id),
    .cmd_long  (cmd_long),
    .btn_level (btn_level)
  );

  always #5 clk = ~clk;

  // Edges since reset release (ticks land where this is a multiple of 10)
  // and a free-running cycle stamp.
  int unsigned ecnt = 0;
  int unsigned cyc  = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  id;
    logic        lng;
    int unsigned t;
  } acc_t;
  acc_t log_q[$];

  always @(posedge clk) begin
    if (!rst && cmd_valid && cmd_ready) log_q.push_back('{cmd_id, cmd_long, cyc});
  end

  typedef struct {
    logic [4:0]      btn;
    int              n;
    logic [4:0][2:0] ids;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic align_tick();
    @(negedge clk);
    while (ecnt % 10 != 0) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned c0;
    int          bad;
    int          n;

    vecs[0].btn = 5'b00010; vecs[0].n = 1; vecs[0].ids = {3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    vecs[1].btn = 5'b10001; vecs[1].n = 2; vecs[1].ids = {3'd0, 3'd0, 3'd0, 3'd4, 3'd0};
    vecs[2].btn = 5'b00100; vecs[2].n = 1; vecs[2].ids = {3'd0, 3'd0, 3'd0, 3'd0, 3'd2};
    vecs[3].btn = 5'b01000; vecs[3].n = 1; vecs[3].ids = {3'd0, 3'd0, 3'd0, 3'd0, 3'd3};
    vecs[4].btn = 5'b11111; vecs[4].n = 5; vecs[4].ids = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst cmd_valid", int'(cmd_valid), 0);
    check("rst cmd_id", int'(cmd_id), 0);
    check("rst cmd_long", int'(cmd_long), 0);
    check("rst btn_level", int'(btn_level), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Table: short presses, priority order, back-to-back service
    for (int v = 0; v < 5; v++) begin
      log_q.delete();
      btn = vecs[v].btn;
      repeat (60) @(negedge clk);
      check($sformatf("vec%0d level held", v), int'(btn_level), int'(vecs[v].btn));
      btn = '0;
      repeat (80) @(negedge clk);
      check($sformatf("vec%0d level released", v), int'(btn_level), 0);
      check($sformatf("vec%0d cmd count", v), log_q.size(), vecs[v].n);
      for (int i = 0; i < vecs[v].n && i < log_q.size(); i++) begin
        check($sformatf("vec%0d id[%0d]", v, i), int'(log_q[i].id), int'(vecs[v].ids[i]));
        check($sformatf("vec%0d long[%0d]", v, i), int'(log_q[i].lng), 0);
        if (i > 0) check($sformatf("vec%0d gap[%0d]", v, i), int'(log_q[i].t - log_q[i-1].t), 1);
      end
    end

    // Exact debounce and first-command latency relative to the sample tick
    log_q.delete();
    align_tick();
    btn[1] = 1'b1;
    repeat (39) @(negedge clk);
    check("lat level before 4th tick", int'(btn_level[1]), 0);
    @(negedge clk);
    check("lat level at 4th tick", int'(btn_level[1]), 1);
    check("lat valid +0", int'(cmd_valid), 0);
    @(negedge clk);
    check("lat valid +1", int'(cmd_valid), 0);
    @(negedge clk);
    check("lat valid +2", int'(cmd_valid), 1);
    check("lat id", int'(cmd_id), 1);
    check("lat long", int'(cmd_long), 0);
    repeat (18) @(negedge clk);
    btn = '0;
    repeat (80) @(negedge clk);
    check("lat single cmd", log_q.size(), 1);

    // Bouncing input never settles
    log_q.delete();
    bad = 0;
    for (int c = 0; c < 200; c++) begin
      if (c % 7 == 0) btn[3] = ~btn[3];
      @(negedge clk);
      if (btn_level[3] || cmd_valid) bad++;
    end
    btn = '0;
    repeat (60) @(negedge clk);
    check("bounce glitch cycles", bad, 0);
    check("bounce cmd count", log_q.size(), 0);

    // Backpressure: held output stays stable until accepted
    log_q.delete();
    cmd_ready = 1'b0;
    btn[2] = 1'b1;
    n = 0;
    while (!cmd_valid && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("stall valid seen", int'(cmd_valid), 1);
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!cmd_valid || cmd_id != 3'd2 || cmd_long) bad++;
    end
    check("stall held stable", bad, 0);
    cmd_ready = 1'b1;
    @(negedge clk);
    check("stall accepted once", log_q.size(), 1);
    if (log_q.size() > 0) check("stall id", int'(log_q[0].id), 2);
    check("stall valid after accept", int'(cmd_valid), 0);
    btn = '0;
    repeat (80) @(negedge clk);
    check("stall no extra cmd", log_q.size(), 1);

    // Long hold: short, first long 200 clocks after level rise, then every 50
    log_q.delete();
    align_tick();
    c0 = cyc;
    btn[0] = 1'b1;
    repeat (400) @(negedge clk);
    btn = '0;
    repeat (120) @(negedge clk);
    check("hold cmd count", log_q.size(), 5);
    for (int i = 0; i < 5 && i < log_q.size(); i++) begin
      check($sformatf("hold id[%0d]", i), int'(log_q[i].id), 0);
      check($sformatf("hold long[%0d]", i), int'(log_q[i].lng), (i == 0) ? 0 : 1);
      check($sformatf("hold time[%0d]", i), int'(log_q[i].t - c0), (i == 0) ? 42 : 241 + 50 * (i - 1));
    end

    // Reset mid-repeat with a long command waiting
    align_tick();
    btn[4] = 1'b1;
    repeat (241) @(negedge clk);
    cmd_ready = 1'b0;
    check("rrst pre valid", int'(cmd_valid), 1);
    check("rrst pre long", int'(cmd_long), 1);
    check("rrst pre id", int'(cmd_id), 4);
    rst = 1'b1;
    @(negedge clk);
    check("rrst valid", int'(cmd_valid), 0);
    check("rrst id", int'(cmd_id), 0);
    check("rrst long", int'(cmd_long), 0);
    check("rrst level", int'(btn_level), 0);
    rst = 1'b0;
    cmd_ready = 1'b1;
    log_q.delete();
    bad = 0;
    for (int c = 0; c < 41; c++) begin
      @(negedge clk);
      if (cmd_valid) bad++;
    end
    check("rrst quiet after release", bad, 0);
    @(negedge clk);
    check("rrst new valid", int'(cmd_valid), 1);
    check("rrst new id", int'(cmd_id), 4);
    check("rrst new long", int'(cmd_long), 0);
    btn = '0;
    repeat (80) @(negedge clk);
    check("rrst cmd count", log_q.size(), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
